gen_scheduler: RTL and testbench
================================

Name: gen_scheduler

Overview:
- Sequences `life_logic` once per generation and owns the write port of the double-buffered board memory.
- Decides when a generation starts: frame-aligned, run, pause, single-step. Decides when the back/front buffers swap.
- Multiplexes the memory write port between `life_logic` writeback and an internal board-clear sweeper.
- Sits between the top-level UI/VGA timing and `life_logic` plus `double_buffer`.

Parameters:
- ADDR_W, LOG_MAX_ADDR (package), width of the board word address.
- DATA_W, WORD_SIZE (package), board word width.
- NUM_WORDS, MAX_ADDR (package), words per buffer; the clear sweep covers 0..NUM_WORDS-1.
- GUARD_CYCLES, 3, cycles after the start pulse during which `logic_done_in` is ignored.
- TIMEOUT_CYCLES, 65535, watchdog limit (used only with `GEN_TIMEOUT_EN`).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- frame_in  in  1  one-cycle pulse at the start of vertical blank.
- run_in  in  1  level; 1 = free-running generations.
- step_in  in  1  pulse; request exactly one generation.
- clear_in  in  1  pulse; request zeroing of both buffers.
- logic_done_in  in  1  `life_logic` done_out.
- logic_wr_en_in  in  1  `life_logic` write enable.
- logic_addr_w_in  in  ADDR_W  `life_logic` write address.
- logic_data_w_in  in  DATA_W  `life_logic` write data.
- logic_start_out  out  1  start pulse to `life_logic`.
- mem_wr_en_out  out  1  double-buffer write enable.
- mem_addr_w_out  out  ADDR_W  double-buffer write address.
- mem_data_w_out  out  DATA_W  double-buffer write data.
- buf_sel_out  out  1  selects the front (display/read) buffer; the back buffer is the other one.
- busy_out  out  1  high whenever state != IDLE.
- gen_count_out  out  16  number of completed generations, wraps at 0xFFFF -> 0.
- err_out  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - All outputs are 0.
  - step_pend = 0, clr_pend = 0.
  - Reset asserted mid-generation or mid-clear aborts immediately. No buffer swap occurs.
- Request latching:
  - step_in sets step_pend in any state. It is cleared on entry to START.
  - clear_in sets clr_pend in any state. It is cleared on entry to CLEAR.
- States:
  - IDLE:
    - On frame_in with clr_pend: go to CLEAR. Clear has priority over step and run.
    - Else on frame_in with (run_in or step_pend): go to START.
    - Else stay.
  - START:
    - logic_start_out = 1 for exactly this one cycle.
    - Load guard counter = GUARD_CYCLES, then go to RUN.
  - RUN:
    - Write port forwards logic_* inputs combinationally: mem_* = logic_*.
    - Decrement guard until 0. logic_done_in is ignored while guard != 0.
    - On logic_done_in with guard == 0: go to SWAP_WAIT.
  - SWAP_WAIT:
    - mem_wr_en_out = 0.
    - On frame_in: toggle buf_sel_out, increment gen_count_out, then:
      - clr_pend: go to CLEAR;
      - else run_in or step_pend: go to START in the same transition;
      - else go to IDLE.
  - CLEAR:
    - Two passes; the pass bit starts at 0.
    - Each cycle: mem_wr_en_out = 1, mem_data_w_out = 0, mem_addr_w_out = sweep address. The sweep address starts at 0 and increments by 1.
    - At address NUM_WORDS-1:
      - pass 0: toggle buf_sel_out, set pass = 1, restart the address at 0;
      - pass 1: toggle buf_sel_out and go to IDLE.
    - gen_count_out is reset to 0 at CLEAR exit.
    - A clear takes 2*NUM_WORDS cycles and leaves buf_sel_out unchanged overall.
- Outside RUN and CLEAR, mem_wr_en_out = 0 and mem_addr_w_out/mem_data_w_out = 0.
- frame_in arriving in START, RUN or CLEAR is ignored; it is not queued.
- run_in dropping during RUN: the current generation completes and swaps; no further start.

Optional Feature:
- Macro: GEN_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter runs in RUN.
  - When it reaches TIMEOUT_CYCLES without a qualified logic_done_in: set err_out (sticky until reset), go to IDLE, no swap.
  - A further clear_in does not reset err_out.
- Undefined: no counter; RUN waits indefinitely; err_out is tied to 0.

Decomposition:
- Shared package (`common.svh`): sched_state_t enum {IDLE, START, RUN, SWAP_WAIT, CLEAR}; reuse the existing addr_t and WORD_SIZE/MAX_ADDR constants.
- One sub-module, clear_sweeper: address counter plus pass bit, with start/done handshake. It drives the address and the wrap toggle pulse.

Test Plan:
- Normal generation:
  - Stimulus: reset, run_in=1, frame_in at cycle 10; model drives logic_done_in at cycle 40.
  - Required response: logic_start_out high only at cycle 11; buf_sel_out 0->1 and gen_count_out=1 on the next frame_in.
- Early done ignored:
  - Stimulus: logic_done_in held high from cycle 11, i.e. the stale done from the previous generation.
  - Required response: no transition to SWAP_WAIT before guard expiry (cycle 11+GUARD_CYCLES).
- Single step:
  - Stimulus: run_in=0, step_in pulse, then 3 frames.
  - Required response: exactly one logic_start_out pulse; gen_count_out=1; state IDLE afterwards.
- Clear during run:
  - Stimulus: NUM_WORDS=16, clear_in pulsed in RUN.
  - Required response: generation completes and swaps; then 32 consecutive zero writes, addresses 0..15 twice; buf_sel toggles twice; gen_count_out=0.
- Reset mid-operation:
  - Stimulus: rst_n_in low at RUN cycle 5.
  - Required response: all outputs 0 asynchronously, before the next clock edge; buf_sel_out=0.
- Watchdog (GEN_TIMEOUT_EN, TIMEOUT_CYCLES=100):
  - Stimulus: never assert logic_done_in.
  - Required response: err_out=1 at RUN cycle 100; state IDLE; buf_sel_out unchanged.

Source files
------------

// File: rtl/gen_scheduler_pkg.sv
// Shared board geometry, word types and scheduler state encoding for the gen_scheduler slice.
package gen_scheduler_pkg;

    localparam int unsigned LOG_MAX_ADDR = 4;
    localparam int unsigned MAX_ADDR     = 15;
    localparam int unsigned WORD_SIZE    = 16;
    localparam int unsigned GEN_COUNT_W  = 16;

    localparam int unsigned ADDR_W    = LOG_MAX_ADDR;
    localparam int unsigned DATA_W    = WORD_SIZE;
    localparam int unsigned NUM_WORDS = MAX_ADDR + 1;

    typedef logic [ADDR_W-1:0]      addr_t;
    typedef logic [DATA_W-1:0]      word_t;
    typedef logic [GEN_COUNT_W-1:0] gen_count_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        SWAP_WAIT,
        CLEAR
    } sched_state_t;

    function automatic logic is_last_word(input addr_t addr, input int unsigned num_words);
        return addr == addr_t'(num_words - 1);
    endfunction

endpackage

// File: rtl/gen_scheduler_if.sv
// Scheduler port bundle: UI/VGA requests, life_logic handshake and writeback, board write port, status.
interface gen_scheduler_if;
    import gen_scheduler_pkg::*;

    logic       frame_in;
    logic       run_in;
    logic       step_in;
    logic       clear_in;
    logic       logic_done_in;
    logic       logic_wr_en_in;
    addr_t      logic_addr_w_in;
    word_t      logic_data_w_in;

    logic       logic_start_out;
    logic       mem_wr_en_out;
    addr_t      mem_addr_w_out;
    word_t      mem_data_w_out;
    logic       buf_sel_out;
    logic       busy_out;
    gen_count_t gen_count_out;
    logic       err_out;

    modport master (
        input  frame_in, run_in, step_in, clear_in,
        input  logic_done_in, logic_wr_en_in, logic_addr_w_in, logic_data_w_in,
        output logic_start_out, mem_wr_en_out, mem_addr_w_out, mem_data_w_out,
        output buf_sel_out, busy_out, gen_count_out, err_out
    );

    modport slave (
        output frame_in, run_in, step_in, clear_in,
        output logic_done_in, logic_wr_en_in, logic_addr_w_in, logic_data_w_in,
        input  logic_start_out, mem_wr_en_out, mem_addr_w_out, mem_data_w_out,
        input  buf_sel_out, busy_out, gen_count_out, err_out
    );

endinterface

// File: rtl/gen_scheduler_clear_sweeper.sv
// Board-clear address generator: sweeps 0..NUM_WORDS-1 twice, pulsing wrap at each pass end.
module gen_scheduler_clear_sweeper
    import gen_scheduler_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  logic  en,
    output addr_t addr,
    output logic  wrap,
    output logic  done
);

    logic pass;
    logic last;

    assign last = is_last_word(addr, NUM_WORDS);
    assign wrap = en && last;
    assign done = wrap && pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            pass <= 1'b0;
        end else if (start) begin
            addr <= '0;
            pass <= 1'b0;
        end else if (en) begin
            if (last) begin
                addr <= '0;
                pass <= !pass;
            end else begin
                addr <= addr + addr_t'(1);
            end
        end
    end

endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: starts life_logic per frame, owns the board write port and buffer swaps.
// Define GEN_TIMEOUT_EN to enable the RUN-state watchdog that drives err_out.
module gen_scheduler
    import gen_scheduler_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    gen_scheduler_if.master bus
);

    localparam int unsigned GUARD_W = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
    typedef logic [GUARD_W-1:0] guard_t;

    sched_state_t state;
    sched_state_t next_state;
    guard_t       guard;
    logic         step_pend;
    logic         clr_pend;
    logic         buf_sel;
    gen_count_t   gen_count;
    logic         done_ok;
    logic         timeout_hit;
    logic         swap_now;
    logic         sweep_start;
    logic         sweep_en;
    logic         sweep_wrap;
    logic         sweep_done;
    addr_t        sweep_addr;

    // The watchdog counter is 16 bits wide; larger or zero limits are not meaningful.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    end

    // A done level left over from the previous generation must not end this one early.
    assign done_ok = bus.logic_done_in && (guard == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state          = state;
        swap_now            = 1'b0;
        bus.logic_start_out = 1'b0;
        bus.mem_wr_en_out   = 1'b0;
        bus.mem_addr_w_out  = '0;
        bus.mem_data_w_out  = '0;
        case (state)
            IDLE: begin
                if (bus.frame_in) begin
                    if (clr_pend) begin
                        next_state = CLEAR;
                    end else if (bus.run_in || step_pend) begin
                        next_state = START;
                    end
                end
            end
            START: begin
                bus.logic_start_out = 1'b1;
                next_state          = RUN;
            end
            RUN: begin
                bus.mem_wr_en_out  = bus.logic_wr_en_in;
                bus.mem_addr_w_out = bus.logic_addr_w_in;
                bus.mem_data_w_out = bus.logic_data_w_in;
                if (done_ok) begin
                    next_state = SWAP_WAIT;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (bus.frame_in) begin
                    swap_now = 1'b1;
                    if (clr_pend) begin
                        next_state = CLEAR;
                    end else if (bus.run_in || step_pend) begin
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            CLEAR: begin
                bus.mem_wr_en_out  = 1'b1;
                bus.mem_addr_w_out = sweep_addr;
                if (sweep_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            guard <= '0;
        end else if (state == START) begin
            guard <= guard_t'(GUARD_CYCLES);
        end else if (state == RUN && guard != '0) begin
            guard <= guard - guard_t'(1);
        end
    end

    // Requests arriving on the consuming edge survive: the new pulse re-arms the flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            step_pend <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            step_pend <= (step_pend && (next_state != START)) || bus.step_in;
            clr_pend  <= (clr_pend && !sweep_start) || bus.clear_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            buf_sel   <= 1'b0;
            gen_count <= '0;
        end else begin
            buf_sel <= buf_sel ^ (swap_now || sweep_wrap);
            if (sweep_done) begin
                gen_count <= '0;
            end else if (swap_now) begin
                gen_count <= gen_count + gen_count_t'(1);
            end
        end
    end

    assign sweep_en    = (state == CLEAR);
    assign sweep_start = (next_state == CLEAR) && (state != CLEAR);

    gen_scheduler_clear_sweeper u_sweeper (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .start (sweep_start),
        .en    (sweep_en),
        .addr  (sweep_addr),
        .wrap  (sweep_wrap),
        .done  (sweep_done)
    );

`ifdef GEN_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err;

    // Counter reads 1 in the first RUN cycle, so the limit is hit in RUN cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == START) begin
                wd_cnt <= 16'd1;
            end else if (state == RUN && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state == RUN) && !done_ok && (wd_cnt == 16'(TIMEOUT_CYCLES));
    assign bus.err_out = err || timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign bus.err_out = 1'b0;
`endif

    assign bus.busy_out      = (state != IDLE);
    assign bus.buf_sel_out   = buf_sel;
    assign bus.gen_count_out = gen_count;

endmodule

// File: tb/tb_gen_scheduler.sv
// Self-checking bench for gen_scheduler: decision table, directed multi-cycle sequences, random run vs model.
module tb_gen_scheduler;
    import gen_scheduler_pkg::*;

    localparam int unsigned GUARD = 3;
    localparam int unsigned TMO   = 100;
    localparam int          NW    = NUM_WORDS;

    typedef struct packed {
        logic        busy;
        logic        start;
        logic        wr;
        addr_t       addr;
        word_t       data;
        logic        front;
        logic [15:0] count;
        logic        err;
    } obs_t;

    typedef struct {
        bit clr;
        bit step;
        bit run;
        bit exp_start;
        bit exp_clear;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    obs_t hist [256];

    // Reference model: generation age, pending-swap flag and remaining clear writes.
    int          m_age;
    bit          m_wait;
    int          m_left;
    bit          m_front;
    logic [15:0] m_count;
    bit          m_step;
    bit          m_clr;
    bit          m_err;

    gen_scheduler_if bus ();

    gen_scheduler #(
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy  = bus.busy_out;
        o.start = bus.logic_start_out;
        o.wr    = bus.mem_wr_en_out;
        o.addr  = bus.mem_addr_w_out;
        o.data  = bus.mem_data_w_out;
        o.front = bus.buf_sel_out;
        o.count = bus.gen_count_out;
        o.err   = bus.err_out;
        return o;
    endfunction

    function automatic bit done_accepted();
        return (m_age >= int'(GUARD) + 1) && (bus.logic_done_in == 1'b1);
    endfunction

    function automatic bit timeout_now();
`ifdef GEN_TIMEOUT_EN
        return (m_age == int'(TMO)) && !done_accepted();
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_age   = -1;
        m_wait  = 1'b0;
        m_left  = 0;
        m_front = 1'b0;
        m_count = '0;
        m_step  = 1'b0;
        m_clr   = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic obs_t model_expect();
        obs_t e;
        e       = '0;
        e.busy  = (m_age >= 0) || m_wait || (m_left > 0);
        e.start = (m_age == 0);
        if (m_age >= 1) begin
            e.wr   = bus.logic_wr_en_in;
            e.addr = bus.logic_addr_w_in;
            e.data = bus.logic_data_w_in;
        end else if (m_left > 0) begin
            e.wr   = 1'b1;
            e.addr = addr_t'((2 * NW - m_left) % NW);
        end
        e.front = m_front;
        e.count = m_count;
        e.err   = m_err || timeout_now();
        return e;
    endfunction

    task automatic launch(input bit go);
        if (m_clr) begin
            m_left = 2 * NW;
            m_clr  = 1'b0;
        end else if (go) begin
            m_age  = 0;
            m_step = 1'b0;
        end
    endtask

    task automatic model_step();
        bit frame;
        bit go;
        bit acc;
        bit tmo;
        frame = bus.frame_in;
        go    = bus.run_in || m_step;
        acc   = done_accepted();
        tmo   = timeout_now();
        if (m_left > 0) begin
            if (m_left == NW + 1 || m_left == 1) m_front = !m_front;
            m_left--;
            if (m_left == 0) m_count = '0;
        end else if (m_wait) begin
            if (frame) begin
                m_front = !m_front;
                m_count = m_count + 16'd1;
                m_wait  = 1'b0;
                launch(go);
            end
        end else if (m_age > 0) begin
            if (acc) begin
                m_age  = -1;
                m_wait = 1'b1;
            end else if (tmo) begin
                m_age = -1;
                m_err = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (frame) begin
            launch(go);
        end
        m_step = m_step || bus.step_in;
        m_clr  = m_clr || bus.clear_in;
    endtask

    // One clock: inputs already set by caller; sample mid-cycle, advance model, clear pulses.
    task automatic cycle();
        obs_t exp_o;
        obs_t act_o;
        #3;
        exp_o = model_expect();
        act_o = dut_obs();
        check($sformatf("cycle%0d", cyc), act_o, exp_o);
        if (cyc < 256) hist[cyc] = act_o;
        model_step();
        @(posedge clk);
        #1;
        bus.frame_in = 1'b0;
        bus.step_in  = 1'b0;
        bus.clear_in = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        bus.frame_in        = 1'b0;
        bus.run_in          = 1'b0;
        bus.step_in         = 1'b0;
        bus.clear_in        = 1'b0;
        bus.logic_done_in   = 1'b0;
        bus.logic_wr_en_in  = 1'b0;
        bus.logic_addr_w_in = '0;
        bus.logic_data_w_in = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_obs(), '0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        vec_t vecs [6];
        int   n;
        int   first_wait;

        vecs[0] = '{0, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 1, 1, 0};
        vecs[2] = '{0, 1, 0, 1, 0};
        vecs[3] = '{1, 0, 0, 0, 1};
        vecs[4] = '{1, 1, 1, 0, 1};
        vecs[5] = '{0, 1, 1, 1, 0};

        // IDLE decision on a frame: clear beats step and run
        for (int i = 0; i < 6; i++) begin
            do_reset();
            cycle();
            bus.clear_in = vecs[i].clr;
            bus.step_in  = vecs[i].step;
            cycle();
            bus.run_in   = vecs[i].run;
            bus.frame_in = 1'b1;
            cycle();
            cycle();
            check($sformatf("vec%0d_start", i), hist[3].start, vecs[i].exp_start);
            check($sformatf("vec%0d_clear_wr", i), hist[3].wr, vecs[i].exp_clear);
            check($sformatf("vec%0d_busy", i), hist[3].busy, vecs[i].exp_start | vecs[i].exp_clear);
        end

        // Normal generation
        do_reset();
        bus.run_in = 1'b1;
        for (int i = 0; i < 56; i++) begin
            bus.frame_in      = (i == 10 || i == 50);
            bus.logic_done_in = (i == 40);
            cycle();
        end
        n = 0;
        for (int i = 0; i < 50; i++) n += int'(hist[i].start);
        check("normal_start_count", 64'(n), 64'd1);
        check("normal_start_at_11", hist[11].start, 1'b1);
        check("normal_front_before", hist[50].front, 1'b0);
        check("normal_front_after", hist[51].front, 1'b1);
        check("normal_count_after", hist[51].count, 16'd1);

        // Stale done held high from the start cycle
        do_reset();
        bus.run_in         = 1'b1;
        bus.logic_wr_en_in = 1'b1;
        for (int i = 0; i < 21; i++) begin
            bus.frame_in      = (i == 10);
            bus.logic_done_in = (i >= 11);
            cycle();
        end
        first_wait = -1;
        for (int i = 12; i < 21; i++) begin
            if (first_wait < 0 && hist[i].busy && !hist[i].start && !hist[i].wr) first_wait = i;
        end
        check("guard_first_swap_wait", 64'(first_wait), 64'd16);

        // Single step
        do_reset();
        for (int i = 0; i < 60; i++) begin
            bus.step_in       = (i == 2);
            bus.frame_in      = (i == 10 || i == 30 || i == 50);
            bus.logic_done_in = (i == 20);
            cycle();
        end
        n = 0;
        for (int i = 0; i < 60; i++) n += int'(hist[i].start);
        check("step_start_count", 64'(n), 64'd1);
        check("step_gen_count", hist[59].count, 16'd1);
        check("step_idle_after", hist[59].busy, 1'b0);

        // Clear requested during RUN
        do_reset();
        bus.run_in = 1'b1;
        for (int i = 0; i < 71; i++) begin
            bus.frame_in      = (i == 10 || i == 30);
            bus.clear_in      = (i == 13);
            bus.logic_done_in = (i == 20);
            cycle();
        end
        n = 0;
        for (int i = 31; i < 63; i++) begin
            if (hist[i].wr && hist[i].data == '0 && int'(hist[i].addr) == (i - 31) % 16) n++;
        end
        check("clear_ordered_writes", 64'(n), 64'd32);
        n = 0;
        for (int i = 25; i < 71; i++) n += int'(hist[i].wr);
        check("clear_total_writes", 64'(n), 64'd32);
        n = 0;
        for (int i = 32; i < 64; i++) n += int'(hist[i].front != hist[i-1].front);
        check("clear_front_toggles", 64'(n), 64'd2);
        check("clear_front_after_swap", hist[31].front, 1'b1);
        check("clear_count_after_swap", hist[31].count, 16'd1);
        check("clear_front_end", hist[63].front, 1'b1);
        check("clear_count_end", hist[63].count, 16'd0);
        check("clear_idle_end", hist[63].busy, 1'b0);

        // Reset asserted in RUN cycle 5 of the second generation
        do_reset();
        bus.run_in          = 1'b1;
        bus.logic_wr_en_in  = 1'b1;
        bus.logic_addr_w_in = addr_t'(5);
        bus.logic_data_w_in = word_t'(16'hABCD);
        for (int i = 0; i < 31; i++) begin
            bus.frame_in      = (i == 10 || i == 25);
            bus.logic_done_in = (i == 20);
            cycle();
        end
        #1;
        check("pre_reset_busy_wr_front", {bus.busy_out, bus.mem_wr_en_out, bus.buf_sel_out}, 3'b111);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", dut_obs(), '0);
        do_reset();

`ifdef GEN_TIMEOUT_EN
        do_reset();
        bus.run_in = 1'b1;
        for (int i = 0; i < 110; i++) begin
            bus.frame_in = (i == 2);
            if (i == 4) bus.run_in = 1'b0;
            cycle();
        end
        check("wd_no_err_before", hist[102].err, 1'b0);
        check("wd_err_at_run100", hist[103].err, 1'b1);
        check("wd_idle_after", hist[104].busy, 1'b0);
        check("wd_front_kept", hist[109].front, 1'b0);
        check("wd_err_sticky", hist[109].err, 1'b1);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.run_in = !bus.run_in;
            bus.frame_in        = ($urandom_range(0, 7) == 0);
            bus.step_in         = ($urandom_range(0, 19) == 0);
            bus.clear_in        = ($urandom_range(0, 59) == 0);
            bus.logic_done_in   = ($urandom_range(0, 5) == 0);
            bus.logic_wr_en_in  = 1'($urandom_range(0, 1));
            bus.logic_addr_w_in = addr_t'($urandom);
            bus.logic_data_w_in = word_t'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
